alu_mc: RTL

- Multi-cycle execution unit at the consuming end of the 4-bit ALU control code produced by the ALU controller.
- Executes and/or/add/sub/slt in one registered cycle and mul with an iterative shift-add engine.
- Uses a start/busy/valid handshake so the datapath can stall during mul.
- Sits between the register-file/immediate mux outputs and the writeback mux.

---
 rtl/alu_mc_if.sv | 54 +++++
 rtl/alu_mc.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle between the datapath and the
// multi-cycle ALU (alu_mc).
//
//   start_i   request strobe, sampled only while busy_o is low
//   ctrl_i    4-bit operation code from the ALU controller
//   src1_i    operand A
//   src2_i    operand B
//   result_o  registered result, held until the next completion
//   zero_o    registered, set when the completed result is all zeros
//   valid_o   one-cycle completion pulse
//   busy_o    high while a multiply is iterating
//   err_o     one-cycle pulse with valid_o for an invalid operation code
//   ovf_o     signed overflow flag for add/sub; present only when
//             ALU_MC_OVF_EN is defined
//
// Modports: master = datapath side, slave = the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             valid_o;
    logic             busy_o;
    logic             err_o;
`ifdef ALU_MC_OVF_EN
    logic             ovf_o;
`endif

`ifdef ALU_MC_OVF_EN
    modport master (
        output start_i, ctrl_i, src1_i, src2_i,
        input  result_o, zero_o, valid_o, busy_o, err_o, ovf_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i,
        output result_o, zero_o, valid_o, busy_o, err_o, ovf_o
    );
`else
    modport master (
        output start_i, ctrl_i, src1_i, src2_i,
        input  result_o, zero_o, valid_o, busy_o, err_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i,
        output result_o, zero_o, valid_o, busy_o, err_o
    );
`endif
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execution unit fed by the ALU controller.
//
// and/or/add/sub/slt complete one cycle after start_i. mul runs an
// iterative shift-add engine for WIDTH cycles while busy_o is high and
// returns the low WIDTH bits of the product. Invalid codes complete in
// one cycle with result 0 and err_o set.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous, active-low reset
//   bus     alu_mc_if.slave (start_i, ctrl_i, src1_i, src2_i in;
//           result_o, zero_o, valid_o, busy_o, err_o [, ovf_o] out)
//
// Parameters:
//   WIDTH   operand/result width (min 4)
//   CNT_W   multiply counter width, 2**CNT_W must exceed WIDTH
//
// Optional feature: define ALU_MC_OVF_EN to add the registered signed
// overflow flag ovf_o for add and sub.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic    clk_i,
    input  logic    rst_i,
    alu_mc_if.slave bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] op_result;
    logic             op_err;
    logic             op_mul;
    logic [WIDTH-1:0] acc_step;
`ifdef ALU_MC_OVF_EN
    logic             op_ovf;
`endif

    // Single-cycle result for the code currently on ctrl_i. A mul
    // code only flags that the iterative engine must be started.
    always_comb begin
        sum       = bus.src1_i + bus.src2_i;
        diff      = bus.src1_i - bus.src2_i;
        op_result = '0;
        op_err    = 1'b0;
        op_mul    = 1'b0;
`ifdef ALU_MC_OVF_EN
        op_ovf    = 1'b0;
`endif
        case (bus.ctrl_i)
            OP_AND: op_result = bus.src1_i & bus.src2_i;
            OP_OR:  op_result = bus.src1_i | bus.src2_i;
            OP_ADD: begin
                op_result = sum;
`ifdef ALU_MC_OVF_EN
                op_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
`endif
            end
            OP_SUB: begin
                op_result = diff;
`ifdef ALU_MC_OVF_EN
                op_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                         (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
`endif
            end
            OP_SLT: op_result = {{(WIDTH-1){1'b0}},
                                 ($signed(bus.src1_i) < $signed(bus.src2_i))};
            OP_MUL: op_mul = 1'b1;
            default: op_err = 1'b1;
        endcase
    end

    // One shift-add step: the accumulator after conditionally adding
    // the current (already shifted) multiplicand.
    always_comb begin
        acc_step = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM and all registered outputs. valid_o and err_o default
    // low so they only pulse on a completion; result/zero/ovf hold.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            cnt          <= '0;
            bus.result_o <= '0;
            bus.zero_o   <= 1'b1;
            bus.valid_o  <= 1'b0;
            bus.busy_o   <= 1'b0;
            bus.err_o    <= 1'b0;
`ifdef ALU_MC_OVF_EN
            bus.ovf_o    <= 1'b0;
`endif
        end else begin
            bus.valid_o <= 1'b0;
            bus.err_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (op_mul) begin
                            mcand      <= bus.src1_i;
                            mplier     <= bus.src2_i;
                            acc        <= '0;
                            cnt        <= CNT_W'(WIDTH);
                            bus.busy_o <= 1'b1;
                            state      <= MUL;
                        end else begin
                            bus.result_o <= op_result;
                            bus.zero_o   <= (op_result == '0);
                            bus.valid_o  <= 1'b1;
                            bus.err_o    <= op_err;
`ifdef ALU_MC_OVF_EN
                            bus.ovf_o    <= op_ovf;
`endif
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // cnt==1 means this edge performs the final step.
                    if (cnt == CNT_W'(1)) begin
                        bus.result_o <= acc_step;
                        bus.zero_o   <= (acc_step == '0);
                        bus.valid_o  <= 1'b1;
                        bus.busy_o   <= 1'b0;
`ifdef ALU_MC_OVF_EN
                        bus.ovf_o    <= 1'b0;
`endif
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
